// File: rtl/snax_dream_stream_ctrl.sv
// snax_dream_stream_ctrl
// Stream controller between a SNAX streamer and NumPE parallel PE lanes.
// A CSR handshake configures mode/addr/beat count N; input beats are fanned
// out to the PE lanes, and PE results are collected in per-lane FIFOs and
// emitted as full-width output beats once every lane has data.
// Optional feature: define SNAX_DREAM_PERF_CNT_EN to add a second read-only
// CSR word holding a saturating count of output stall cycles.
module snax_dream_stream_ctrl #(
  parameter int NumPE        = 4,
  parameter int DataWidth    = 512,
  parameter int FifoDepth    = 4,
  parameter int RegDataWidth = 32,
`ifdef SNAX_DREAM_PERF_CNT_EN
  localparam int RegROCount  = 2
`else
  localparam int RegROCount  = 1
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumPE*DataWidth-1:0]   stream2acc_0_data_i,
  input  logic                         stream2acc_0_valid_i,
  output logic                         stream2acc_0_ready_o,
  output logic [NumPE*DataWidth-1:0]   acc2stream_0_data_o,
  output logic                         acc2stream_0_valid_o,
  input  logic                         acc2stream_0_ready_i,
  output logic [DataWidth-1:0]         pe_a_o [NumPE],
  output logic                         pe_a_valid_o,
  input  logic [NumPE-1:0]             pe_a_ready_i,
  input  logic [DataWidth-1:0]         pe_c_i [NumPE],
  input  logic [NumPE-1:0]             pe_c_valid_i,
  output logic [NumPE-1:0]             pe_c_ready_o,
  output logic [1:0]                   pe_mode_o,
  output logic [6:0]                   pe_addr_o,
  input  logic [RegDataWidth-1:0]      csr_reg_set_i [2],
  input  logic                         csr_reg_set_valid_i,
  output logic                         csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0]      csr_reg_ro_set_o [RegROCount]
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [1:0]  r_mode;
  logic [6:0]  r_addr;
  logic [15:0] r_num;
  logic [15:0] r_inCnt;
  logic [15:0] r_outCnt;
  logic        r_done;

  logic [DataWidth-1:0] r_mem   [NumPE][FifoDepth];
  logic [PtrW-1:0]      r_wrPtr [NumPE];
  logic [PtrW-1:0]      r_rdPtr [NumPE];
  logic [CntW-1:0]      r_count [NumPE];

  logic [NumPE-1:0] w_full;
  logic [NumPE-1:0] w_empty;
  logic [NumPE-1:0] w_push;
  logic             w_csrFire;
  logic             w_inFire;
  logic             w_outFire;
  logic             w_inLast;
  logic             w_outLast;
  logic [15:0]      w_csrNum;
  logic [RegDataWidth-1:0] w_ro0;
  logic             w_unused;

`ifdef SNAX_DREAM_PERF_CNT_EN
  logic [31:0] r_stallCnt;
`endif

  // Only the low CSR fields carry configuration; the rest are don't-care.
  assign w_unused = ^{csr_reg_set_i[0][RegDataWidth-1:9], csr_reg_set_i[1][RegDataWidth-1:16]};

  assign w_csrNum            = csr_reg_set_i[1][15:0];
  assign csr_reg_set_ready_o = (r_state == IDLE) & ~rst_i;
  assign w_csrFire           = csr_reg_set_valid_i & csr_reg_set_ready_o;

  assign stream2acc_0_ready_o = (r_state == RUN) & (&pe_a_ready_i);
  assign pe_a_valid_o         = (r_state == RUN) & stream2acc_0_valid_i;
  assign w_inFire             = stream2acc_0_valid_i & stream2acc_0_ready_o;
  assign w_inLast             = (r_inCnt + 16'd1) == r_num;

  assign pe_c_ready_o = ~w_full & {NumPE{~rst_i}};
  assign w_push       = pe_c_valid_i & pe_c_ready_o;

  assign acc2stream_0_valid_o = ~(|w_empty) & (r_outCnt < r_num) & (r_state != IDLE) & ~rst_i;
  assign w_outFire            = acc2stream_0_valid_o & acc2stream_0_ready_i;
  assign w_outLast            = (r_outCnt + 16'd1) == r_num;

  assign pe_mode_o = r_mode;
  assign pe_addr_o = r_addr;

  // Split the input beat into per-lane operands for the PEs.
  always_comb begin
    for (int i = 0; i < NumPE; i++) begin
      pe_a_o[i] = stream2acc_0_data_i[i*DataWidth +: DataWidth];
    end
  end

  // Per-lane FIFO status flags derived from the occupancy counters.
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    for (int i = 0; i < NumPE; i++) begin
      w_full[i]  = (r_count[i] == CntW'(FifoDepth));
      w_empty[i] = (r_count[i] == '0);
    end
  end

  // Output beat is the concatenation of every lane's FIFO head (registered storage).
  always_comb begin
    acc2stream_0_data_o = '0;
    for (int i = 0; i < NumPE; i++) begin
      acc2stream_0_data_o[i*DataWidth +: DataWidth] = r_mem[i][r_rdPtr[i]];
    end
  end

  // FIFO storage; contents are not reset because pointers define validity.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumPE; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wrPtr[i]] <= pe_c_i[i];
      end
    end
  end

  // FIFO pointers and occupancy; all lanes pop together on an output handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumPE; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumPE; i++) begin
        if (w_push[i]) begin
          r_wrPtr[i] <= r_wrPtr[i] + 1'b1;
        end
        if (w_outFire) begin
          r_rdPtr[i] <= r_rdPtr[i] + 1'b1;
        end
        case ({w_push[i], w_outFire})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: finishing the last output wins over finishing the last input.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_csrFire && (w_csrNum != 16'd0)) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_outFire && w_outLast) begin
          w_nextState = IDLE;
        end else if (w_inFire && w_inLast) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_outFire && w_outLast) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Configuration latch, beat counters and done flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode   <= '0;
      r_addr   <= '0;
      r_num    <= '0;
      r_inCnt  <= '0;
      r_outCnt <= '0;
      r_done   <= 1'b0;
    end else if (w_csrFire) begin
      r_mode   <= csr_reg_set_i[0][1:0];
      r_addr   <= csr_reg_set_i[0][8:2];
      r_num    <= w_csrNum;
      r_inCnt  <= '0;
      r_outCnt <= '0;
      r_done   <= (w_csrNum == 16'd0);
    end else begin
      if (w_inFire) begin
        r_inCnt <= r_inCnt + 16'd1;
      end
      if (w_outFire) begin
        r_outCnt <= r_outCnt + 16'd1;
      end
      if ((r_state != IDLE) && w_outFire && w_outLast) begin
        r_done <= 1'b1;
      end
    end
  end

`ifdef SNAX_DREAM_PERF_CNT_EN
  // Saturating count of busy cycles where an output beat is offered but refused.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stallCnt <= '0;
    end else if (w_csrFire) begin
      r_stallCnt <= '0;
    end else if ((r_state != IDLE) && acc2stream_0_valid_o && !acc2stream_0_ready_i
                 && (r_stallCnt != 32'hFFFF_FFFF)) begin
      r_stallCnt <= r_stallCnt + 32'd1;
    end
  end
`endif

  // Read-only status words.
  always_comb begin
    w_ro0        = '0;
    w_ro0[15:0]  = r_outCnt;
    w_ro0[16]    = r_done;
    w_ro0[31]    = (r_state != IDLE);
    csr_reg_ro_set_o[0] = w_ro0;
`ifdef SNAX_DREAM_PERF_CNT_EN
    csr_reg_ro_set_o[1] = RegDataWidth'(r_stallCnt);
`endif
  end

endmodule

// File: tb/tb_snax_dream_stream_ctrl.sv
// tb_snax_dream_stream_ctrl
// Directed bench for snax_dream_stream_ctrl with an echoing PE model and a
// controllable output sink. Perf-counter checks are compiled in only when
// SNAX_DREAM_PERF_CNT_EN is defined.
module tb_snax_dream_stream_ctrl;

  localparam int NumPE        = 4;
  localparam int DataWidth    = 32;
  localparam int FifoDepth    = 4;
  localparam int RegDataWidth = 32;
`ifdef SNAX_DREAM_PERF_CNT_EN
  localparam int RegROCount   = 2;
`else
  localparam int RegROCount   = 1;
`endif

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic [NumPE*DataWidth-1:0]  stream2acc_0_data_i;
  logic                        stream2acc_0_valid_i;
  logic                        stream2acc_0_ready_o;
  logic [NumPE*DataWidth-1:0]  acc2stream_0_data_o;
  logic                        acc2stream_0_valid_o;
  logic                        acc2stream_0_ready_i;
  logic [DataWidth-1:0]        pe_a_o [NumPE];
  logic                        pe_a_valid_o;
  logic [NumPE-1:0]            pe_a_ready_i;
  logic [DataWidth-1:0]        pe_c_i [NumPE];
  logic [NumPE-1:0]            pe_c_valid_i;
  logic [NumPE-1:0]            pe_c_ready_o;
  logic [1:0]                  pe_mode_o;
  logic [6:0]                  pe_addr_o;
  logic [RegDataWidth-1:0]     csr_reg_set_i [2];
  logic                        csr_reg_set_valid_i;
  logic                        csr_reg_set_ready_o;
  logic [RegDataWidth-1:0]     csr_reg_ro_set_o [RegROCount];

  int checks = 0;
  int errors = 0;
  int sinkMode = 0;
  int cyc = 0;
  int inFires = 0;
  int stallCnt = 0;
  logic [127:0] peQ [$];
  logic [127:0] outQ [$];

  snax_dream_stream_ctrl #(
    .NumPE(NumPE), .DataWidth(DataWidth), .FifoDepth(FifoDepth), .RegDataWidth(RegDataWidth)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .stream2acc_0_data_i(stream2acc_0_data_i), .stream2acc_0_valid_i(stream2acc_0_valid_i),
    .stream2acc_0_ready_o(stream2acc_0_ready_o),
    .acc2stream_0_data_o(acc2stream_0_data_o), .acc2stream_0_valid_o(acc2stream_0_valid_o),
    .acc2stream_0_ready_i(acc2stream_0_ready_i),
    .pe_a_o(pe_a_o), .pe_a_valid_o(pe_a_valid_o), .pe_a_ready_i(pe_a_ready_i),
    .pe_c_i(pe_c_i), .pe_c_valid_i(pe_c_valid_i), .pe_c_ready_o(pe_c_ready_o),
    .pe_mode_o(pe_mode_o), .pe_addr_o(pe_addr_o),
    .csr_reg_set_i(csr_reg_set_i), .csr_reg_set_valid_i(csr_reg_set_valid_i),
    .csr_reg_set_ready_o(csr_reg_set_ready_o), .csr_reg_ro_set_o(csr_reg_ro_set_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Echo PE model: every accepted input beat comes back unchanged as a result.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peQ.delete();
    end else begin
      if (pe_c_valid_i[0] && (&pe_c_ready_o)) begin
        void'(peQ.pop_front());
      end
      if (stream2acc_0_valid_i && stream2acc_0_ready_o) begin
        peQ.push_back(stream2acc_0_data_i);
        inFires++;
      end
    end
  end

  // Present the oldest echoed result to all lanes together, only when every lane can take it.
  always @(negedge clk_i) begin
    pe_c_valid_i = ((peQ.size() > 0) && (&pe_c_ready_o) && !rst_i) ? 4'hF : 4'h0;
    for (int i = 0; i < NumPE; i++) begin
      pe_c_i[i] = (peQ.size() > 0) ? peQ[0][i*DataWidth +: DataWidth] : '0;
    end
  end

  // Output sink ready pattern: 0 = always ready, 1 = toggle, 2 = stalled.
  always @(negedge clk_i) begin
    cyc++;
    case (sinkMode)
      0:       acc2stream_0_ready_i = 1'b1;
      1:       acc2stream_0_ready_i = cyc[0];
      default: acc2stream_0_ready_i = 1'b0;
    endcase
  end

  // Record delivered output beats and count stalled busy cycles.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (acc2stream_0_valid_o && acc2stream_0_ready_i) begin
        outQ.push_back(acc2stream_0_data_o);
      end
      if (csr_reg_set_valid_i && csr_reg_set_ready_o) begin
        stallCnt <= 0;
      end else if (csr_reg_ro_set_o[0][31] && acc2stream_0_valid_o && !acc2stream_0_ready_i) begin
        stallCnt <= stallCnt + 1;
      end
    end else begin
      stallCnt <= 0;
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] mkBeat(input int n);
    return {32'hA300_0000 + n, 32'hA200_0000 + n, 32'hA100_0000 + n, 32'hA000_0000 + n};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one input beat and hold it until the controller takes it.
  task automatic applyStimulus(input logic [127:0] beat);
    int k = 0;
    stream2acc_0_data_i  = beat;
    stream2acc_0_valid_i = 1'b1;
    #1;
    while (!stream2acc_0_ready_o && k < 50) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    checkOutput("in_accept", stream2acc_0_ready_o, 1'b1);
    @(negedge clk_i);
    stream2acc_0_valid_i = 1'b0;
  endtask

  task automatic csrWrite(input logic [31:0] cfg0, input logic [31:0] cfg1);
    int k = 0;
    csr_reg_set_i[0]    = cfg0;
    csr_reg_set_i[1]    = cfg1;
    csr_reg_set_valid_i = 1'b1;
    #1;
    while (!csr_reg_set_ready_o && k < 50) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    checkOutput("csr_accept", csr_reg_set_ready_o, 1'b1);
    @(negedge clk_i);
    csr_reg_set_valid_i = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    @(negedge clk_i);
    while (csr_reg_ro_set_o[0][31] && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput(tag, csr_reg_ro_set_o[0][31], 1'b0);
  endtask

  int base;
  int fires0;

  initial begin
    rst_i                = 1'b1;
    stream2acc_0_data_i  = '0;
    stream2acc_0_valid_i = 1'b0;
    pe_a_ready_i         = 4'hF;
    csr_reg_set_i[0]     = '0;
    csr_reg_set_i[1]     = '0;
    csr_reg_set_valid_i  = 1'b0;
    sinkMode             = 0;

    // Reset behaviour.
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rst_handshakes_low",
                {csr_reg_set_ready_o, pe_c_ready_o, acc2stream_0_valid_o, stream2acc_0_ready_o, pe_a_valid_o}, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("rst_csr_ready", csr_reg_set_ready_o, 1'b1);
    checkOutput("rst_ro0", csr_reg_ro_set_o[0], 32'h0);
    checkOutput("rst_pe_c_ready", pe_c_ready_o, 4'hF);
    @(negedge clk_i);

    // Single beat job: mode 2, addr 0x15, N=1.
    $display("[TB] single beat");
    base = outQ.size();
    csrWrite(32'h56, 32'd1);
    checkOutput("single_mode", pe_mode_o, 2'd2);
    checkOutput("single_addr", pe_addr_o, 7'h15);
    checkOutput("single_busy", csr_reg_ro_set_o[0], 32'h8000_0000);
    applyStimulus(mkBeat(0));
    waitIdle("single_idle");
    checkOutput("single_count", outQ.size() - base, 1);
    checkOutput("single_data", outQ[base], mkBeat(0));
    checkOutput("single_ro0", csr_reg_ro_set_o[0], 32'h0001_0001);

    // Backpressure job: N=8, sink stalled while feeding, then toggling.
    $display("[TB] backpressure");
    sinkMode = 2;
    base = outQ.size();
    csrWrite(32'h9, 32'd8);
    for (int i = 0; i < 8; i++) applyStimulus(mkBeat(10 + i));
    repeat (4) @(negedge clk_i);
    #1;
    checkOutput("bp_fifo_full_ready", pe_c_ready_o, 4'h0);
    checkOutput("bp_valid_held", acc2stream_0_valid_o, 1'b1);
    checkOutput("bp_none_out", csr_reg_ro_set_o[0][15:0], 16'd0);
    sinkMode = 1;
    waitIdle("bp_idle");
    checkOutput("bp_count", outQ.size() - base, 8);
    for (int i = 0; i < 8; i++) checkOutput("bp_data", outQ[base + i], mkBeat(10 + i));
    checkOutput("bp_ro0", csr_reg_ro_set_o[0], 32'h0001_0008);
`ifdef SNAX_DREAM_PERF_CNT_EN
    checkOutput("bp_perf", csr_reg_ro_set_o[1], stallCnt);
`endif

    // Lane skew: one lane not ready blocks the whole beat.
    $display("[TB] lane skew");
    sinkMode = 0;
    base = outQ.size();
    csrWrite(32'h6, 32'd2);
    fires0 = inFires;
    stream2acc_0_data_i  = mkBeat(20);
    stream2acc_0_valid_i = 1'b1;
    pe_a_ready_i         = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("skew_ready_low", stream2acc_0_ready_o, 1'b0);
      @(negedge clk_i);
    end
    checkOutput("skew_pe_a_valid", pe_a_valid_o, 1'b1);
    checkOutput("skew_no_consume", inFires - fires0, 0);
    pe_a_ready_i = 4'hF;
    applyStimulus(mkBeat(20));
    applyStimulus(mkBeat(21));
    waitIdle("skew_idle");
    checkOutput("skew_count", outQ.size() - base, 2);
    checkOutput("skew_data0", outQ[base], mkBeat(20));
    checkOutput("skew_data1", outQ[base + 1], mkBeat(21));

    // Zero-length job and CSR write while busy.
    $display("[TB] zero and busy");
    csrWrite(32'h7, 32'd0);
    checkOutput("zero_ro0_done", csr_reg_ro_set_o[0], 32'h0001_0000);
    checkOutput("zero_csr_ready", csr_reg_set_ready_o, 1'b1);
    checkOutput("zero_mode", pe_mode_o, 2'd3);
    checkOutput("zero_addr", pe_addr_o, 7'h01);
    @(negedge clk_i);
    checkOutput("zero_not_busy", csr_reg_ro_set_o[0][31], 1'b0);
    base = outQ.size();
    csrWrite(32'h101, 32'd3);
    csr_reg_set_i[0]    = 32'h1FE;
    csr_reg_set_i[1]    = 32'd5;
    csr_reg_set_valid_i = 1'b1;
    #1;
    checkOutput("busy_csr_ready", csr_reg_set_ready_o, 1'b0);
    @(negedge clk_i);
    #1;
    checkOutput("busy_csr_ready2", csr_reg_set_ready_o, 1'b0);
    csr_reg_set_valid_i = 1'b0;
    checkOutput("busy_mode", pe_mode_o, 2'd1);
    checkOutput("busy_addr", pe_addr_o, 7'h40);
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) applyStimulus(mkBeat(30 + i));
    waitIdle("busy_idle");
    checkOutput("busy_count", outQ.size() - base, 3);
    checkOutput("busy_ro0", csr_reg_ro_set_o[0], 32'h0001_0003);

    // Reset in the middle of a 6-beat job, then a fresh 2-beat job.
    $display("[TB] reset mid-op");
    sinkMode = 2;
    base = outQ.size();
    csrWrite(32'h5, 32'd6);
    for (int i = 0; i < 6; i++) applyStimulus(mkBeat(40 + i));
    sinkMode = 0;
    begin
      int k = 0;
      while (outQ.size() < base + 3 && k < 100) begin
        @(negedge clk_i);
        k++;
      end
    end
    checkOutput("mid_three_out", outQ.size() - base, 3);
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_handshakes",
                {csr_reg_set_ready_o, pe_c_ready_o, acc2stream_0_valid_o, stream2acc_0_ready_o, pe_a_valid_o}, '0);
    checkOutput("mid_rst_ro0", csr_reg_ro_set_o[0], 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("mid_release_ready", csr_reg_set_ready_o, 1'b1);
    checkOutput("mid_release_ro0", csr_reg_ro_set_o[0], 32'h0);
    @(negedge clk_i);
    base = outQ.size();
    csrWrite(32'h5, 32'd2);
    applyStimulus(mkBeat(50));
    applyStimulus(mkBeat(51));
    waitIdle("fresh_idle");
    checkOutput("fresh_count", outQ.size() - base, 2);
    checkOutput("fresh_data0", outQ[base], mkBeat(50));
    checkOutput("fresh_data1", outQ[base + 1], mkBeat(51));
    checkOutput("fresh_ro0", csr_reg_ro_set_o[0], 32'h0001_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snax_dream_stream_ctrl.md
SNAX_DREAM_STREAM_CTRL -- requirements
Module: snax_dream_stream_ctrl

Interface
- REQ-001 SHALL have parameter NumPE, default 4: number of parallel PE lanes.
- REQ-002 SHALL have parameter DataWidth, default 512: bits per lane.
- REQ-003 SHALL have parameter FifoDepth, default 4: per-lane output FIFO entries; power of two, >=2.
- REQ-004 SHALL have parameter RegDataWidth, default 32: CSR word width.
- REQ-005 SHALL use one clock and an asynchronous, active-high reset, as ports 1 and 2:
  - clk_i  in  1  clock.
  - rst_i  in  1  asynchronous active-high reset.
- REQ-006 SHALL have the following stream-side ports:
  - stream2acc_0_data_i  in  NumPE*DataWidth  input beat; lane i = bits [i*DataWidth +: DataWidth].
  - stream2acc_0_valid_i  in  1.
  - stream2acc_0_ready_o  out  1.
  - acc2stream_0_data_o  out  NumPE*DataWidth  output beat.
  - acc2stream_0_valid_o  out  1.
  - acc2stream_0_ready_i  in  1.
- REQ-007 SHALL have the following PE-side ports:
  - pe_a_o  out  NumPE x DataWidth.
  - pe_a_valid_o  out  1.
  - pe_a_ready_i  in  NumPE.
  - pe_c_i  in  NumPE x DataWidth.
  - pe_c_valid_i  in  NumPE.
  - pe_c_ready_o  out  NumPE.
  - pe_mode_o  out  2.
  - pe_addr_o  out  7.
- REQ-008 SHALL have the following CSR ports:
  - csr_reg_set_i  in  2 x RegDataWidth.
  - csr_reg_set_valid_i  in  1.
  - csr_reg_set_ready_o  out  1.
  - csr_reg_ro_set_o  out  RegROCount x RegDataWidth; RegROCount = 1, or 2 with the perf macro.

Function
- REQ-009 SHALL implement FSM states IDLE, RUN, DRAIN.
- REQ-010 SHALL drive csr_reg_set_ready_o=1 only in IDLE.
- REQ-011 SHALL latch the following on a valid&ready CSR handshake:
  - csr_reg_set_i[0][1:0] as mode.
  - csr_reg_set_i[0][8:2] as addr.
  - csr_reg_set_i[1][15:0] as beat count N.
- REQ-012 SHALL, on a CSR handshake, clear the input and output beat counters and the done bit, then go to RUN if N>0; if N==0, stay in IDLE and set done the next cycle.
- REQ-013 SHALL drive pe_mode_o and pe_addr_o from the latched registers, held stable from the cycle after the handshake until the next handshake.
- REQ-014 SHALL drive pe_a_o combinationally from the stream2acc_0_data_i lane slices.
- REQ-015 SHALL assert pe_a_valid_o = stream2acc_0_valid_i only in RUN.
- REQ-016 SHALL assert stream2acc_0_ready_o = (state==RUN) & (&pe_a_ready_i); an input beat transfers only when every lane is ready, with no partial-lane acceptance.
- REQ-017 SHALL count accepted input beats; when the count reaches N on an acceptance edge, the next state SHALL be DRAIN.
- REQ-018 SHALL give each lane a FifoDepth output FIFO with pe_c_ready_o[i] = !full[i]; a write occurs on pe_c_valid_i[i]&pe_c_ready_o[i].
- REQ-019 SHALL make written data visible at the FIFO head no earlier than the following cycle, with no combinational path from pe_c_i to acc2stream_0_data_o.
- REQ-020 SHALL assert acc2stream_0_valid_o only when all lane FIFOs are non-empty and the output counter is below N.
- REQ-021 SHALL, on a valid&ready output handshake, pop all lanes together and increment the output counter.
- REQ-022 SHALL not move the FIFO count on a simultaneous push and pop to the same lane; a push to a full lane SHALL never occur; FIFO pointers SHALL wrap modulo FifoDepth.
- REQ-023 SHALL, in RUN or DRAIN, return to IDLE and set done the cycle after the output counter reaches N.
- REQ-024 SHALL take the last input and last output in the same cycle as a RUN->IDLE transition.
- REQ-025 SHALL report csr_reg_ro_set_o[0] as:
  - [15:0] output beats completed.
  - [16] done.
  - [31] busy (state!=IDLE).
  - All other bits 0.
- REQ-026 SHALL ignore CSR writes while busy, with ready held low.

Reset
- REQ-027 SHALL, while rst_i is asserted at any time including mid-transfer, immediately clear state to IDLE, counters, FIFO pointers, mode, addr, N, done and perf counter.
- REQ-028 SHALL force all valid and ready outputs to 0 during reset, except that csr_reg_set_ready_o=1 after reset release.
- REQ-029 SHALL discard in-flight FIFO data on reset.

Configuration
- REQ-030 SHALL, with SNAX_DREAM_PERF_CNT_EN defined:
  - set RegROCount=2.
  - report in csr_reg_ro_set_o[1] a saturating 32-bit count of cycles in RUN/DRAIN where acc2stream_0_valid_o=1 and acc2stream_0_ready_i=0.
  - clear that count on each CSR handshake.
- REQ-031 SHALL, without SNAX_DREAM_PERF_CNT_EN, set RegROCount=1 and contain no perf logic.

Verification
- REQ-032 Single beat: NumPE=4, N=1, PE echo, sink always ready -> exactly 1 output beat equal to the input; RO0 = 0x0001_0001 after completion.
- REQ-033 Backpressure: N=8, acc2stream_0_ready_i toggling every cycle -> 8 in-order beats, no loss or duplication; pe_c_ready_o[i] deasserts when a lane holds FifoDepth entries; perf count (macro on) equals the stalled valid cycles.
- REQ-034 Lane skew: pe_a_ready_i=4'b0111 for 3 cycles -> stream2acc_0_ready_o=0 for those cycles; no input beat consumed.
- REQ-035 Zero and busy: N=0 -> busy never set, done=1 one cycle after the handshake; a CSR write during RUN -> csr_reg_set_ready_o=0, latched config unchanged.
- REQ-036 Reset mid-op: assert rst_i after 3 of 6 outputs -> all outputs idle and RO0=0 the same cycle; a fresh N=2 job then completes normally.
